// File: rtl/lite16_loader_pkg.sv
// lite16_loader_pkg
// Shared types and constants for the LITE-16 program-memory loader.
//   state_t           : loader FSM states
//   SYNC_BYTE_DEFAULT : frame start marker
//   LEN_W             : width of the frame length / word counters
package lite16_loader_pkg;

    localparam int         LEN_W             = 16;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// prog_loader
// Accepts a framed byte stream (SYNC, LEN_HI, LEN_LO, 2*LEN data bytes, CHK)
// and writes the assembled 16-bit words into program memory from address 0.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid, in_data      : byte stream input
//   in_ready               : byte accepted when in_valid && in_ready
//   wr_en, wr_addr, wr_data: single-cycle memory write port
//   busy                   : frame in progress (state != IDLE)
//   done, error            : one-cycle completion / failure pulses
//   words_written          : words written in the current or last frame
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | drop bytes until SYNC_BYTE
// LEN_HI  | wait for length high byte
// LEN_LO  | wait for length low byte, range-check length
// DATA_HI | wait for high byte of next word
// DATA_LO | wait for low byte, issue write
// CHECK   | compare checksum byte against accumulator
// DONE    | one-cycle good-frame pulse
// ERR     | one-cycle bad checksum / oversize pulse
module prog_loader
    import lite16_loader_pkg::*;
#(
    parameter int         MEM_SIZE  = 127,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [15:0]      wr_addr,
    output logic [15:0]      wr_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_written
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_SIZE + 1);

    state_t           state, state_next;
    logic [LEN_W-1:0] remaining, remaining_next;
    logic [15:0]      addr, addr_next;
    logic [7:0]       hi_byte, hi_byte_next;
    logic [7:0]       chk, chk_next;
    logic [LEN_W-1:0] words_next;
    logic             in_ready_next, wr_en_next;
    logic [15:0]      wr_addr_next, wr_data_next;
    logic             accept;
    logic [LEN_W-1:0] len_rx;

    assign accept = in_valid && in_ready;
    // LEN_HI is parked in the upper byte of the remaining counter until LEN_LO arrives.
    assign len_rx = {remaining[15:8], in_data};

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        addr_next      = addr;
        hi_byte_next   = hi_byte;
        chk_next       = chk;
        words_next     = words_written;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        case (state)
            IDLE: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_next = LEN_HI;
                    words_next = '0;
                    addr_next  = '0;
                    chk_next   = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    remaining_next = {in_data, 8'h00};
                    state_next     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    remaining_next = len_rx;
                    if (len_rx > MAX_LEN)
                        state_next = ERR;
                    else if (len_rx == '0)
                        state_next = CHECK;
                    else
                        state_next = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_byte_next = in_data;
                    chk_next     = chk ^ in_data;
                    state_next   = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    wr_en_next     = 1'b1;
                    wr_addr_next   = addr;
                    wr_data_next   = {hi_byte, in_data};
                    addr_next      = addr + 16'd1;
                    words_next     = words_written + 16'd1;
                    chk_next       = chk ^ in_data;
                    remaining_next = remaining - 16'd1;
                    state_next     = (remaining == 16'd1) ? CHECK : DATA_HI;
                end
            end
            CHECK: begin
                if (accept)
                    state_next = (in_data == chk) ? DONE : ERR;
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Registered ready: low exactly while sitting in the DONE/ERR cycle.
        in_ready_next = (state_next != DONE) && (state_next != ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            remaining     <= '0;
            addr          <= '0;
            hi_byte       <= '0;
            chk           <= '0;
            words_written <= '0;
            in_ready      <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
        end else begin
            state         <= state_next;
            remaining     <= remaining_next;
            addr          <= addr_next;
            hi_byte       <= hi_byte_next;
            chk           <= chk_next;
            words_written <= words_next;
            in_ready      <= in_ready_next;
            wr_en         <= wr_en_next;
            wr_addr       <= wr_addr_next;
            wr_data       <= wr_data_next;
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign error = (state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, wr_en, busy, done, error;
    logic [15:0] wr_addr, wr_data, words_written;

    prog_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // write / pulse monitor, sampled on the falling edge
    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];
    int done_cnt, err_cnt, both_cnt, done_cyc, err_cyc, last_wr, min_gap;

    always @(negedge clk) begin
        if (wr_en) begin
            if (last_wr >= 0 && (cyc - last_wr) < min_gap) min_gap = cyc - last_wr;
            last_wr = cyc;
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (done)  begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++;  err_cyc  = cyc; end
        if (done && error) both_cnt++;
    end

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        done_cnt = 0; err_cnt = 0; both_cnt = 0;
        done_cyc = -1; err_cyc = -1; last_wr = -1; min_gap = 1000;
    endtask

    logic [7:0] tx_q[$];
    int         acc_q[$];
    int         last_acc;

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        int n;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; last_acc = cyc; end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte timeout byte=%h", b);
        end
    endtask

    task automatic send_q(input int maxgap);
        acc_q.delete();
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            acc_q.push_back(last_acc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic load_good_frame();
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    endtask

    task automatic check_two_writes(input string tag);
        checks++;
        if (wa_q.size() !== 2) begin
            errors++; $display("FAIL %s write_count got %0d exp 2", tag, wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 16'd0 || wd_q[0] !== 16'h1234) begin
                errors++; $display("FAIL %s wr0 got %h:%h exp 0000:1234", tag, wa_q[0], wd_q[0]);
            end
            checks++;
            if (wa_q[1] !== 16'd1 || wd_q[1] !== 16'hABCD) begin
                errors++; $display("FAIL %s wr1 got %h:%h exp 0001:abcd", tag, wa_q[1], wd_q[1]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, wr_en, busy, done, error} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {in_ready, wr_en, busy, done, error});
        end
        checks++;
        if (wr_addr !== 16'd0 || wr_data !== 16'd0 || words_written !== 16'd0) begin
            errors++; $display("FAIL reset_buses got %h %h %h exp 0", wr_addr, wr_data, words_written);
        end
        rst = 1'b0;
        clear_mon();
        wait_cycles(2);
    endtask

    task automatic test_good_frame();
        clear_mon();
        load_good_frame();
        send_q(0);
        wait_cycles(3);
        check_two_writes("good");
        if (wc_q.size() == 2) begin
            checks++;
            if (wc_q[0] !== acc_q[4] + 1 || wc_q[1] !== acc_q[6] + 1) begin
                errors++; $display("FAIL good wr_latency got %0d,%0d exp %0d,%0d",
                                   wc_q[0], wc_q[1], acc_q[4] + 1, acc_q[6] + 1);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== acc_q[7] + 1) begin
            errors++; $display("FAIL good done got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", done_cnt, done_cyc, acc_q[7] + 1);
        end
        checks++;
        if (err_cnt !== 0) begin errors++; $display("FAIL good error_pulses got %0d exp 0", err_cnt); end
        checks++;
        if (words_written !== 16'd2) begin errors++; $display("FAIL good words_written got %0d exp 2", words_written); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL good busy_after got %b exp 0", busy); end
    endtask

    task automatic test_bad_checksum();
        clear_mon();
        load_good_frame();
        tx_q[7] = 8'h41;
        send_q(0);
        wait_cycles(3);
        check_two_writes("badchk");
        checks++;
        if (err_cnt !== 1 || err_cyc !== acc_q[7] + 1 || done_cnt !== 0) begin
            errors++; $display("FAIL badchk pulses got err=%0d@%0d done=%0d exp err=1@%0d done=0",
                               err_cnt, err_cyc, done_cnt, acc_q[7] + 1);
        end
        clear_mon();
        load_good_frame();
        send_q(0);
        wait_cycles(3);
        check_two_writes("recover");
        checks++;
        if (done_cnt !== 1 || err_cnt !== 0) begin
            errors++; $display("FAIL recover pulses got done=%0d err=%0d exp 1,0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_oversize();
        clear_mon();
        tx_q = '{8'hA5, 8'h00, 8'h81};
        send_q(0);
        wait_cycles(3);
        checks++;
        if (err_cnt !== 1 || err_cyc !== acc_q[2] + 1 || done_cnt !== 0) begin
            errors++; $display("FAIL oversize pulses got err=%0d@%0d done=%0d exp err=1@%0d done=0",
                               err_cnt, err_cyc, done_cnt, acc_q[2] + 1);
        end
        checks++;
        if (wa_q.size() !== 0) begin errors++; $display("FAIL oversize writes got %0d exp 0", wa_q.size()); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL oversize busy_after got %b exp 0", busy); end
    endtask

    task automatic test_max_len();
        logic [7:0] c;
        int bad;
        clear_mon();
        c = 8'h00;
        tx_q = '{8'hA5, 8'h00, 8'h80};
        for (int i = 0; i < 128; i++) begin
            tx_q.push_back(8'(i * 3));
            tx_q.push_back(8'(8'h5A ^ i));
            c = c ^ 8'(i * 3) ^ 8'(8'h5A ^ i);
        end
        tx_q.push_back(c);
        send_q(0);
        wait_cycles(3);
        checks++;
        if (wa_q.size() !== 128) begin
            errors++; $display("FAIL maxlen write_count got %0d exp 128", wa_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 128; i++)
                if (wa_q[i] !== 16'(i) || wd_q[i] !== {8'(i * 3), 8'(8'h5A ^ i)}) bad++;
            checks++;
            if (bad !== 0) begin errors++; $display("FAIL maxlen write_content got %0d bad exp 0 bad", bad); end
        end
        checks++;
        if (done_cnt !== 1 || err_cnt !== 0) begin
            errors++; $display("FAIL maxlen pulses got done=%0d err=%0d exp 1,0", done_cnt, err_cnt);
        end
        checks++;
        if (words_written !== 16'd128) begin errors++; $display("FAIL maxlen words_written got %0d exp 128", words_written); end
    endtask

    task automatic test_zero_len();
        clear_mon();
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q(0);
        wait_cycles(3);
        checks++;
        if (done_cnt !== 1 || done_cyc !== acc_q[3] + 1 || err_cnt !== 0) begin
            errors++; $display("FAIL zerolen pulses got done=%0d@%0d err=%0d exp 1@%0d,0",
                               done_cnt, done_cyc, err_cnt, acc_q[3] + 1);
        end
        checks++;
        if (words_written !== 16'd0 || wa_q.size() !== 0) begin
            errors++; $display("FAIL zerolen words got ww=%0d writes=%0d exp 0,0", words_written, wa_q.size());
        end
    endtask

    task automatic test_garbage();
        logic [7:0] g[3];
        g = '{8'h00, 8'hFF, 8'h5A};
        clear_mon();
        foreach (g[i]) begin
            send_byte(g[i], 0);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL garbage busy byte=%h got %b exp 0", g[i], busy); end
        end
        send_byte(8'hA5, 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL garbage busy_after_sync got %b exp 1", busy); end
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_q(0);
        wait_cycles(3);
        check_two_writes("garbage");
        checks++;
        if (done_cnt !== 1 || err_cnt !== 0) begin
            errors++; $display("FAIL garbage pulses got done=%0d err=%0d exp 1,0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_gaps();
        for (int rep = 0; rep < 3; rep++) begin
            clear_mon();
            load_good_frame();
            send_q(5);
            wait_cycles(3);
            check_two_writes("gaps");
            checks++;
            if (min_gap < 2) begin errors++; $display("FAIL gaps wr_spacing got %0d exp >=2", min_gap); end
            checks++;
            if (done_cnt !== 1 || err_cnt !== 0) begin
                errors++; $display("FAIL gaps pulses got done=%0d err=%0d exp 1,0", done_cnt, err_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        int chk_acc;
        clear_mon();
        load_good_frame();
        send_q(0);
        chk_acc = acc_q[7];
        // next SYNC offered immediately, i.e. during the DONE cycle
        load_good_frame();
        send_q(0);
        checks++;
        if (acc_q[0] !== chk_acc + 2) begin
            errors++; $display("FAIL b2b sync_accept got %0d exp %0d", acc_q[0], chk_acc + 2);
        end
        wait_cycles(3);
        checks++;
        if (done_cnt !== 2 || err_cnt !== 0 || wa_q.size() !== 4) begin
            errors++; $display("FAIL b2b totals got done=%0d err=%0d writes=%0d exp 2,0,4",
                               done_cnt, err_cnt, wa_q.size());
        end
        checks++;
        if (min_gap < 2) begin errors++; $display("FAIL b2b wr_spacing got %0d exp >=2", min_gap); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        send_q(0);
        // first write is on the output now; reset for one cycle
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, wr_en, busy, done, error} !== 5'b0 || wr_addr !== 16'd0 ||
            wr_data !== 16'd0 || words_written !== 16'd0) begin
            errors++; $display("FAIL midrst outputs got %b %h %h %h exp all 0",
                               {in_ready, wr_en, busy, done, error}, wr_addr, wr_data, words_written);
        end
        rst = 1'b0;
        wait_cycles(6);
        checks++;
        if (wa_q.size() !== 1 || done_cnt !== 0 || err_cnt !== 0) begin
            errors++; $display("FAIL midrst after got writes=%0d done=%0d err=%0d exp 1,0,0",
                               wa_q.size(), done_cnt, err_cnt);
        end
        clear_mon();
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h56, 8'h78, 8'h2E};
        send_q(0);
        wait_cycles(3);
        checks++;
        if (wa_q.size() !== 1 || wa_q[0] !== 16'd0 || wd_q[0] !== 16'h5678 || done_cnt !== 1) begin
            errors++; $display("FAIL midrst reload got writes=%0d done=%0d exp 1 write 0000:5678 done=1",
                               wa_q.size(), done_cnt);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_oversize();
        test_max_len();
        test_zero_len();
        test_garbage();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL done_and_error_together got %0d exp 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
